// File: rtl/dict_scan_pkg.sv
// Shared types and constants for the dictionary scan controller.
// Holds the digest width default, the controller state encoding and the
// width of the optional scan-cycle counter (DICT_SCAN_CYCLE_CNT_EN).
package dict_scan_pkg;

    // SHA-1 digest width
    localparam int HASH_W_DEF  = 160;
    // Dictionary memory address width
    localparam int ADDR_W_DEF  = 10;
    // Width of the optional busy-cycle counter
    localparam int SCAN_CNT_W  = 32;
    // Slice width used by the chunked equality comparator
    localparam int CMP_CHUNK_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/hash_cmp.sv
// Full-width digest equality comparator with a registered target operand.
// The target is captured on load; the dictionary word is compared against it
// combinationally so a match can steer the controller in the same cycle the
// memory data arrives. The compare is split into fixed-width slices whose
// results are AND-reduced, keeping each slice a short carry-free tree.
module hash_cmp
    import dict_scan_pkg::*;
#(
    parameter int HASH_W = HASH_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [HASH_W-1:0] target,
    input  logic [HASH_W-1:0] data,
    output logic              eq
);

    localparam int N_CHUNK = (HASH_W + CMP_CHUNK_W - 1) / CMP_CHUNK_W;

    logic [HASH_W-1:0]  target_reg;
    logic [N_CHUNK-1:0] chunk_eq;

    // Capture the target digest when a scan is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_reg <= '0;
        end else if (load) begin
            target_reg <= target;
        end
    end

    // Per-slice equality; the last slice may be narrower than CMP_CHUNK_W
    generate
        for (genvar gi = 0; gi < N_CHUNK; gi++) begin : g_chunk
            localparam int LO = gi * CMP_CHUNK_W;
            localparam int HI = ((gi + 1) * CMP_CHUNK_W > HASH_W) ?
                                (HASH_W - 1) : ((gi + 1) * CMP_CHUNK_W - 1);
            assign chunk_eq[gi] = (target_reg[HI:LO] == data[HI:LO]);
        end
    endgenerate

    assign eq = &chunk_eq;

endmodule

// File: rtl/dict_scan_ctrl.sv
// Dictionary scan controller: streams dictionary hashes out of a memory with
// one-cycle read latency, compares each against a latched target digest and
// reports the lowest matching index.
// Optional feature macro: DICT_SCAN_CYCLE_CNT_EN adds the 32-bit scan_cycles
// output counting busy cycles of the most recent scan (saturating).
module dict_scan_ctrl
    import dict_scan_pkg::*;
#(
    parameter int HASH_W = HASH_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [HASH_W-1:0] target_hash,
    input  logic [ADDR_W:0]   dict_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [HASH_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] match_idx,
    output logic [HASH_W-1:0] match_hash
`ifdef DICT_SCAN_CYCLE_CNT_EN
    ,
    output logic [SCAN_CNT_W-1:0] scan_cycles
`endif
);

    state_t            state_reg;
    logic [ADDR_W:0]   len_reg;
    logic              rd_vld_reg;   // mem_rd_data carries a real read this cycle
    logic [ADDR_W-1:0] rd_idx_reg;   // address of the read now on mem_rd_data
    logic              start_ok;
    logic              cmp_eq;
    logic              hit;
    logic              last_addr;

    assign start_ok = start && (state_reg == ST_IDLE);

    // Target is held inside the comparator; loaded on every accepted start
    hash_cmp #(
        .HASH_W (HASH_W)
    ) u_hash_cmp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start_ok),
        .target (target_hash),
        .data   (mem_rd_data),
        .eq     (cmp_eq)
    );

    // A compare only counts when the data bus carries the reply to a read we issued
    assign hit = rd_vld_reg && cmp_eq;

    // Final address reached; the all-ones guard keeps the counter from wrapping
    assign last_addr = ({1'b0, mem_addr} == (len_reg - (ADDR_W + 1)'(1))) ||
                       (&mem_addr);

    // Track which read (if any) is returning on mem_rd_data this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_reg <= 1'b0;
            rd_idx_reg <= '0;
        end else begin
            rd_vld_reg <= mem_rd_en;
            rd_idx_reg <= mem_addr;
        end
    end

    // Main controller FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            len_reg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            match_idx  <= '0;
            match_hash <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        len_reg  <= dict_len;
                        found    <= 1'b0;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                        if (dict_len == '0) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= ST_SCAN;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end

                ST_SCAN: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                        mem_rd_en <= 1'b0;
                        found     <= 1'b0;
                    end else if (hit) begin
                        state_reg  <= ST_DONE;
                        done       <= 1'b1;
                        mem_rd_en  <= 1'b0;
                        found      <= 1'b1;
                        match_idx  <= rd_idx_reg;
                        match_hash <= mem_rd_data;
                    end else if (last_addr) begin
                        state_reg <= ST_DRAIN;
                        mem_rd_en <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end

                ST_DRAIN: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                        found     <= 1'b0;
                    end else if (hit) begin
                        state_reg  <= ST_DONE;
                        done       <= 1'b1;
                        found      <= 1'b1;
                        match_idx  <= rd_idx_reg;
                        match_hash <= mem_rd_data;
                    end else begin
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                        found     <= 1'b0;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    mem_rd_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef DICT_SCAN_CYCLE_CNT_EN
    // Busy-cycle counter: cleared by an accepted start, saturates at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cycles <= '0;
        end else if (start_ok) begin
            scan_cycles <= '0;
        end else if ((state_reg != ST_IDLE) && (scan_cycles != '1)) begin
            scan_cycles <= scan_cycles + SCAN_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dict_scan_ctrl.sv
// Self-checking bench for dict_scan_ctrl. A behavioural dictionary memory
// answers reads one cycle later; expected results are pushed to a scoreboard
// queue when a scan is started and popped when done is observed.
module tb_dict_scan_ctrl;

    localparam int HASH_W = 160;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        bit                found;
        int                idx;
        logic [HASH_W-1:0] hash;
        int                cyc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [HASH_W-1:0] target_hash;
    logic [ADDR_W:0]   dict_len;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [HASH_W-1:0] mem_rd_data;
    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W-1:0] match_idx;
    logic [HASH_W-1:0] match_hash;
`ifdef DICT_SCAN_CYCLE_CNT_EN
    logic [31:0]       scan_cycles;
`endif

    logic [HASH_W-1:0] mem [DEPTH];
    exp_t              exp_q[$];
    int                rd_q[$];
    int                pass_cnt;
    int                total_cnt;

    dict_scan_ctrl #(
        .HASH_W (HASH_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .target_hash (target_hash),
        .dict_len    (dict_len),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .match_idx   (match_idx),
        .match_hash  (match_hash)
`ifdef DICT_SCAN_CYCLE_CNT_EN
        ,
        .scan_cycles (scan_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dictionary memory; when no read is issued the bus shows the target,
    // so a controller that compares unqualified data would see false hits
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        else           mem_rd_data <= target_hash;
    end

    // Record every issued read address
    always @(negedge clk) begin
        if (rst_n && mem_rd_en) rd_q.push_back(int'(mem_addr));
    end

    // Run one scan, scoreboarding the completion against a reference search
    task automatic run_scan(input string name, input int len,
                            input logic [HASH_W-1:0] tgt,
                            input int abort_at, input int restart_at);
        exp_t e;
        exp_t got;
        int   k;
        int   exp_reads;
        int   done_cnt;
        int   bad_addr;
        bit   exp_done;
        k = -1;
        for (int i = 0; i < len; i++) if (k < 0 && mem[i] == tgt) k = i;
        exp_done = (abort_at < 0);
        if (exp_done) begin
            e.found = (k >= 0);
            e.idx   = (k >= 0) ? k : 0;
            e.hash  = (k >= 0) ? mem[k] : '0;
            e.cyc   = (len == 0) ? 1 : ((k >= 0) ? k + 3 : len + 2);
            exp_q.push_back(e);
        end
        if (len == 0)      exp_reads = 0;
        else if (!exp_done) exp_reads = (abort_at < len) ? abort_at : len;
        else if (k >= 0)   exp_reads = (k + 2 < len) ? k + 2 : len;
        else               exp_reads = len;

        @(negedge clk);
        rd_q.delete();
        start       = 1'b1;
        dict_len    = (ADDR_W + 1)'(len);
        target_hash = tgt;
        @(posedge clk); #1;
        start    = 1'b0;
        done_cnt = 0;
        for (int n = 1; n <= len + 12; n++) begin
            abort = (n == abort_at);
            if (n == restart_at) begin
                start       = 1'b1;
                target_hash = ~tgt;
                dict_len    = (ADDR_W + 1)'(2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL %s unexpected_done: done seen at cycle %0d, none expected", name, n);
                end else begin
                    got = exp_q.pop_front();
                    total_cnt++;
                    if (n !== got.cyc) $display("FAIL %s done_cycle: got %0d want %0d", name, n, got.cyc);
                    else pass_cnt++;
                    total_cnt++;
                    if (found !== got.found) $display("FAIL %s found: got %0b want %0b", name, found, got.found);
                    else pass_cnt++;
                    if (got.found) begin
                        total_cnt++;
                        if (int'(match_idx) !== got.idx) $display("FAIL %s match_idx: got %0d want %0d", name, match_idx, got.idx);
                        else pass_cnt++;
                        total_cnt++;
                        if (match_hash !== got.hash) $display("FAIL %s match_hash: got %h want %h", name, match_hash, got.hash);
                        else pass_cnt++;
                    end
                end
            end
            if (abort_at >= 0 && n == abort_at + 1) begin
                total_cnt++;
                if ({busy, found, mem_rd_en} !== 3'b000)
                    $display("FAIL %s abort_state: got busy/found/rd_en=%b want 000", name, {busy, found, mem_rd_en});
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;

        total_cnt++;
        if (done_cnt !== (exp_done ? 1 : 0)) $display("FAIL %s done_pulses: got %0d want %0d", name, done_cnt, exp_done ? 1 : 0);
        else pass_cnt++;
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL %s timeout: done never seen", name);
            exp_q.delete();
        end
        total_cnt++;
        if (rd_q.size() !== exp_reads) $display("FAIL %s read_count: got %0d want %0d", name, rd_q.size(), exp_reads);
        else pass_cnt++;
        bad_addr = 0;
        foreach (rd_q[i]) if (rd_q[i] !== i) bad_addr++;
        total_cnt++;
        if (bad_addr !== 0) $display("FAIL %s addr_seq: got %0d out-of-order addresses want 0", name, bad_addr);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s idle_after: got busy=%0b want 0", name, busy);
        else pass_cnt++;
`ifdef DICT_SCAN_CYCLE_CNT_EN
        total_cnt++;
        if (int'(scan_cycles) !== (exp_done ? e.cyc : abort_at))
            $display("FAIL %s scan_cycles: got %0d want %0d", name, scan_cycles, exp_done ? e.cyc : abort_at);
        else pass_cnt++;
`endif
        $display("scan %s len=%0d idx=%0d abort_at=%0d reads=%0d", name, len, k, abort_at, rd_q.size());
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if ({busy, done, found, mem_rd_en} !== 4'b0000)
            $display("FAIL reset_flags: got busy/done/found/rd_en=%b want 0000", {busy, done, found, mem_rd_en});
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== '0 || match_idx !== '0) $display("FAIL reset_addr: got addr=%0d idx=%0d want 0 0", mem_addr, match_idx);
        else pass_cnt++;
        total_cnt++;
        if (match_hash !== '0) $display("FAIL reset_hash: got %h want 0", match_hash);
        else pass_cnt++;
        $display("reset checked");
    endtask

    task automatic test_match();
        run_scan("match5", 8, mem[5], -1, -1);
        run_scan("match_idx3", 8, mem[3], -1, -1);
        run_scan("match_last", 4, mem[3], -1, -1);
        run_scan("match_first", 8, mem[0], -1, -1);
    endtask

    task automatic test_miss();
        logic [HASH_W-1:0] near;
        near      = mem[5];
        near[159] = ~near[159];
        run_scan("miss8", 8, near, -1, -1);
    endtask

    task automatic test_lowest_wins();
        logic [HASH_W-1:0] save;
        save   = mem[6];
        mem[6] = mem[2];
        run_scan("two_matches", 8, mem[2], -1, -1);
        mem[6] = save;
    endtask

    task automatic test_len_zero();
        run_scan("len0", 0, mem[0], -1, -1);
    endtask

    task automatic test_start_busy();
        run_scan("start_busy", 8, mem[5], -1, 3);
    endtask

    task automatic test_abort();
        run_scan("abort4", 16, mem[12], 4, -1);
        run_scan("abort_prio", 8, mem[2], 4, -1);
        run_scan("abort_drain", 4, mem[10], 5, -1);
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        start       = 1'b1;
        dict_len    = (ADDR_W + 1)'(16);
        target_hash = mem[9];
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, found, mem_rd_en} !== 4'b0000)
            $display("FAIL rst_mid_flags: got busy/done/found/rd_en=%b want 0000", {busy, done, found, mem_rd_en});
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== '0 || match_idx !== '0 || match_hash !== '0)
            $display("FAIL rst_mid_regs: got addr=%0d idx=%0d hash=%h want zeros", mem_addr, match_idx, match_hash);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid-scan checked");
        run_scan("after_reset", 8, mem[5], -1, -1);
    endtask

    task automatic test_full_range();
        logic [HASH_W-1:0] near;
        near    = mem[1000];
        near[0] = ~near[0];
        near[150] = ~near[150];
        run_scan("full_range", DEPTH, near, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_scan("b2b_a", 6, mem[4], -1, -1);
        run_scan("b2b_b", 6, mem[1], -1, -1);
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        target_hash = '0;
        dict_len    = '0;
        for (int i = 0; i < DEPTH; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom, 22'h0, 10'(i)};
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_match();
        test_miss();
        test_lowest_wins();
        test_len_zero();
        test_start_busy();
        test_abort();
        test_reset_mid_scan();
        test_full_range();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dict_scan_ctrl.md
DICT_SCAN_CTRL -- requirements
Module: dict_scan_ctrl

Interface
REQ-001 Parameter HASH_W, default 160, SHA-1 digest width in bits.
REQ-002 Parameter ADDR_W, default 10, dictionary memory address width.
REQ-003 Port clk  input  1  single clock; all logic on posedge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  begin scan; sampled only in IDLE.
REQ-006 Port abort  input  1  cancel scan in progress.
REQ-007 Port target_hash  input  HASH_W  hashed password; latched on accepted start.
REQ-008 Port dict_len  input  ADDR_W+1  number of dictionary entries; latched on accepted start.
REQ-009 Port mem_rd_en  output  1  dictionary read strobe.
REQ-010 Port mem_addr  output  ADDR_W  dictionary read address.
REQ-011 Port mem_rd_data  input  HASH_W  hashed dictionary word, valid exactly one cycle after mem_rd_en.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port done  output  1  one-cycle completion pulse.
REQ-014 Port found  output  1  last completed scan matched.
REQ-015 Port match_idx  output  ADDR_W  index of the matching entry.
REQ-016 Port match_hash  output  HASH_W  matching dictionary hash.

Function
REQ-017 FSM states: IDLE, SCAN, DRAIN, DONE.
REQ-018 IDLE: start=1 latches target_hash and dict_len, clears found, and moves to SCAN; when dict_len=0 it moves to DONE instead.
REQ-019 SCAN: mem_rd_en=1 each cycle; mem_addr starts at 0 and increments by 1 per cycle.
REQ-020 SCAN: after issuing address dict_len-1, the FSM moves to DRAIN and mem_rd_en drops.
REQ-021 Compare mem_rd_data with the latched target in the cycle after each read; equality is a full HASH_W-bit match.
REQ-022 On the first match: stop issuing reads, register found=1, the address of that read to match_idx, and mem_rd_data to match_hash, then move to DONE; the lowest matching index wins.
REQ-023 Any in-flight read that returns after a match is ignored.
REQ-024 DRAIN: compare the final read; on a match, behave as REQ-022; otherwise found=0 and move to DONE.
REQ-025 DONE: done=1 for exactly one cycle, then return to IDLE.
REQ-026 Latency from start accepted in cycle 0: match at index k gives done in cycle k+3; a miss gives done in cycle dict_len+2; dict_len=0 gives done in cycle 1.
REQ-027 found, match_idx and match_hash hold their values until the next accepted start.
REQ-028 start while busy=1 is ignored.
REQ-029 abort=1 in SCAN or DRAIN returns to IDLE next cycle: no done pulse, found=0, mem_rd_en=0.
REQ-030 abort has priority over a same-cycle match; abort in IDLE or DONE has no effect.
REQ-031 The address counter never wraps; dict_len=2^ADDR_W scans every address exactly once.

Reset
REQ-032 rst_n=0 asynchronously forces state=IDLE and busy=0, done=0, found=0, mem_rd_en=0, mem_addr=0, match_idx=0, match_hash=0.
REQ-033 Reset asserted mid-scan discards all progress; the first start after reset release behaves as a fresh scan.

Configuration
REQ-034 Macro DICT_SCAN_CYCLE_CNT_EN, when defined, adds output scan_cycles (32-bit): it clears on accepted start, increments each busy cycle, saturates at all-ones, and resets to 0.
REQ-035 Without DICT_SCAN_CYCLE_CNT_EN, port scan_cycles and its counter do not exist; all other behaviour is identical.

Structure
REQ-036 Shared package dict_scan_pkg holds HASH_W default, state enum type, and the scan_cycles width constant.
REQ-037 Sub-module hash_cmp holds the registered HASH_W equality comparator, reused from the password-compare datapath.

Verification
REQ-038 dict_len=8, match at entry 5 only -> done at cycle 8, found=1, match_idx=5, match_hash=entry 5.
REQ-039 dict_len=8, no match -> done at cycle 10, found=0, 8 reads issued, addresses 0..7.
REQ-040 Matches at entries 2 and 6 -> match_idx=2; no mem_rd_en after cycle 4.
REQ-041 dict_len=0 -> done at cycle 1, found=0, no reads; start while busy -> ignored, target unchanged.
REQ-042 abort at cycle 4 of a 16-entry scan -> IDLE at cycle 5, no done, found=0; rst_n pulse mid-scan -> all outputs 0 immediately.
REQ-043 With DICT_SCAN_CYCLE_CNT_EN, match at index 3 -> scan_cycles=6 after done.
